// File: rtl/rvfi_seq_gen_if.sv
// Control and status bundle for the multi-lane stimulus sequencer.
// The master side starts and stalls playback. The slave side is the
// sequencer, which drives the lane values, lane enables and status.
// RISCV_FORMAL_SEQ_ASSUME_EN adds the din lanes, which the sequencer constrains.
interface rvfi_seq_gen_if #(
  parameter int NCHAN = 1,
  parameter int WIDTH = 4
);
  logic                   start;
  logic                   stall;
`ifdef RISCV_FORMAL_SEQ_ASSUME_EN
  logic [NCHAN*WIDTH-1:0] din;
`endif
  logic [NCHAN*WIDTH-1:0] dout;
  logic [NCHAN-1:0]       en;
  logic                   busy;
  logic                   done;
  logic [6:0]             step_idx;

`ifdef RISCV_FORMAL_SEQ_ASSUME_EN
  modport master (output start, output stall, output din,
                  input dout, input en, input busy, input done, input step_idx);
  modport slave  (input start, input stall, input din,
                  output dout, output en, output busy, output done, output step_idx);
`else
  modport master (output start, output stall,
                  input dout, input en, input busy, input done, input step_idx);
  modport slave  (input start, input stall,
                  output dout, output en, output busy, output done, output step_idx);
`endif
endinterface

// File: rtl/rvfi_seq_gen.sv
// Multi-lane stimulus sequencer. It plays the character-coded string SEQ
// across NCHAN lanes at one step per clock. Playback can be one-shot or can
// repeat, and it supports start/stall control, a per-lane hold code ('=')
// and busy/done status. All outputs come from registers.
// Optional feature: RISCV_FORMAL_SEQ_ASSUME_EN adds the din lanes. Under YOSYS
// it also adds an immediate assume that ties each enabled din lane to dout.

`ifdef RISCV_FORMAL_SEQ_ASSUME_EN
// Formal-only constraint: each enabled din lane follows its dout lane.
module rvfi_seq_gen_assume #(
  parameter int NCHAN = 1,
  parameter int WIDTH = 4
) (
  input logic [NCHAN-1:0]       en,
  input logic [NCHAN*WIDTH-1:0] dout,
  input logic [NCHAN*WIDTH-1:0] din
);
`ifdef YOSYS
  // Force the solver to match din to dout on every enabled lane
  always_comb begin
    for (int k = 0; k < NCHAN; k++) begin
      assume (!en[k] || (din[k*WIDTH +: WIDTH] == dout[k*WIDTH +: WIDTH]));
    end
  end
`else
  logic unused_s;
  assign unused_s = ^{en, dout, din};
`endif
endmodule
`endif

module rvfi_seq_gen #(
  parameter logic [1023:0] SEQ    = {1024{1'b0}},
  parameter int            LEN    = 1,
  parameter int            NCHAN  = 1,
  parameter int            WIDTH  = 4,
  parameter int            REPEAT = 0
) (
  input logic          clock,
  input logic          resetn,
  rvfi_seq_gen_if.slave bus
);
  localparam int         LW        = NCHAN * WIDTH;
  localparam int         STEPS     = LEN / NCHAN;
  localparam logic [6:0] LAST_STEP = 7'(STEPS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state_r, state_nxt_s;
  logic [6:0]      step_r, step_nxt_s;
  logic [LW-1:0]   hold_r, hold_nxt_s;
  logic [LW-1:0]   dout_r, dout_nxt_s;
  logic [NCHAN-1:0] en_r, en_nxt_s;
  logic            busy_r, busy_nxt_s;
  logic            done_r, done_nxt_s;
  logic            load_s;
  logic [WIDTH:0]  dec_s;

  // Character for a lane in a step. The string is right-justified in SEQ,
  // so its leftmost character sits at the top. Within a step, the leftmost
  // character belongs to lane NCHAN-1.
  function automatic logic [7:0] seq_char(input int step, input int lane);
    int ofs;
    ofs = LEN - (step + 1) * NCHAN + lane;
    return SEQ[ofs*8 +: 8];
  endfunction

  // Decode one character to {enable, value}. Hex digits are truncated to WIDTH.
  function automatic logic [WIDTH:0] decode_char(input logic [7:0] ch,
                                                 input logic [WIDTH-1:0] hold);
    logic [3:0]     nib;
    logic [WIDTH:0] res;
    nib = 4'd0;
    res = {(WIDTH+1){1'b0}};
    if (ch >= 8'h30 && ch <= 8'h39) begin
      nib = 4'(ch - 8'h30);
      res = {1'b1, nib[WIDTH-1:0]};
    end else if (ch >= 8'h61 && ch <= 8'h66) begin
      nib = 4'(ch - 8'h57);
      res = {1'b1, nib[WIDTH-1:0]};
    end else if (ch >= 8'h41 && ch <= 8'h46) begin
      nib = 4'(ch - 8'h37);
      res = {1'b1, nib[WIDTH-1:0]};
    end else if (ch == 8'h5f) begin
      res = {1'b1, {WIDTH{1'b0}}};
    end else if (ch == 8'h2d) begin
      res = {1'b1, {WIDTH{1'b1}}};
    end else if (ch == 8'h3d) begin
      res = {1'b1, hold};
    end else begin
      res = {(WIDTH+1){1'b0}};
    end
    return res;
  endfunction

  // Next state, step position, hold registers and registered output values
  always_comb begin
    state_nxt_s = state_r;
    step_nxt_s  = step_r;
    hold_nxt_s  = hold_r;
    dout_nxt_s  = dout_r;
    en_nxt_s    = en_r;
    busy_nxt_s  = busy_r;
    done_nxt_s  = 1'b0;
    load_s      = 1'b0;
    dec_s       = {(WIDTH+1){1'b0}};

    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_nxt_s = ST_RUN;
          step_nxt_s  = 7'd0;
          hold_nxt_s  = {LW{1'b0}};
          load_s      = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
          step_nxt_s  = 7'd0;
          dout_nxt_s  = {LW{1'b0}};
          en_nxt_s    = {NCHAN{1'b0}};
          busy_nxt_s  = 1'b0;
        end
      end
      ST_RUN: begin
        if (bus.start) begin
          step_nxt_s = 7'd0;
          hold_nxt_s = {LW{1'b0}};
          load_s     = 1'b1;
        end else if (bus.stall) begin
          state_nxt_s = ST_RUN;
        end else begin
          // Leaving a step: remember every value that was driven with en=1
          for (int k = 0; k < NCHAN; k++) begin
            if (en_r[k]) begin
              hold_nxt_s[k*WIDTH +: WIDTH] = dout_r[k*WIDTH +: WIDTH];
            end else begin
              hold_nxt_s[k*WIDTH +: WIDTH] = hold_r[k*WIDTH +: WIDTH];
            end
          end
          if (step_r == LAST_STEP) begin
            if (REPEAT != 0) begin
              step_nxt_s = 7'd0;
              load_s     = 1'b1;
            end else begin
              state_nxt_s = ST_DONE;
              dout_nxt_s  = {LW{1'b0}};
              en_nxt_s    = {NCHAN{1'b0}};
              busy_nxt_s  = 1'b0;
              done_nxt_s  = 1'b1;
            end
          end else begin
            step_nxt_s = step_r + 7'd1;
            load_s     = 1'b1;
          end
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        step_nxt_s  = 7'd0;
        hold_nxt_s  = {LW{1'b0}};
        dout_nxt_s  = {LW{1'b0}};
        en_nxt_s    = {NCHAN{1'b0}};
        busy_nxt_s  = 1'b0;
      end
    endcase

    // Entering a step: decode its characters against the updated hold values
    if (load_s) begin
      busy_nxt_s = 1'b1;
      for (int k = 0; k < NCHAN; k++) begin
        dec_s = decode_char(seq_char(int'(step_nxt_s), k),
                            hold_nxt_s[k*WIDTH +: WIDTH]);
        en_nxt_s[k]                  = dec_s[WIDTH];
        dout_nxt_s[k*WIDTH +: WIDTH] = dec_s[WIDTH-1:0];
      end
    end else begin
      busy_nxt_s = busy_nxt_s;
    end
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
      step_r  <= 7'd0;
      hold_r  <= {LW{1'b0}};
      dout_r  <= {LW{1'b0}};
      en_r    <= {NCHAN{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      step_r  <= step_nxt_s;
      hold_r  <= hold_nxt_s;
      dout_r  <= dout_nxt_s;
      en_r    <= en_nxt_s;
      busy_r  <= busy_nxt_s;
      done_r  <= done_nxt_s;
    end
  end

  assign bus.dout     = dout_r;
  assign bus.en       = en_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.step_idx = step_r;

`ifdef RISCV_FORMAL_SEQ_ASSUME_EN
  rvfi_seq_gen_assume #(
    .NCHAN (NCHAN),
    .WIDTH (WIDTH)
  ) u_assume (
    .en   (en_r),
    .dout (dout_r),
    .din  (bus.din)
  );
`endif
endmodule

// File: tb/tb_rvfi_seq_gen.sv
// Bench for rvfi_seq_gen. It drives four differently configured instances
// with shared start/stall/reset stimulus and compares every instance, on
// every cycle, against a string-level playback model.
module tb_rvfi_seq_gen;
  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic start_v = 1'b0;
  logic stall_v = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  rvfi_seq_gen_if #(.NCHAN(1), .WIDTH(4)) ifa ();
  rvfi_seq_gen_if #(.NCHAN(2), .WIDTH(2)) ifb ();
  rvfi_seq_gen_if #(.NCHAN(1), .WIDTH(4)) ifc ();
  rvfi_seq_gen_if #(.NCHAN(2), .WIDTH(3)) ifd ();

  assign ifa.start = start_v;  assign ifa.stall = stall_v;
  assign ifb.start = start_v;  assign ifb.stall = stall_v;
  assign ifc.start = start_v;  assign ifc.stall = stall_v;
  assign ifd.start = start_v;  assign ifd.stall = stall_v;
`ifdef RISCV_FORMAL_SEQ_ASSUME_EN
  assign ifa.din = ifa.dout;
  assign ifb.din = ifb.dout;
  assign ifc.din = ifc.dout;
  assign ifd.din = ifd.dout;
`endif

  rvfi_seq_gen #(.SEQ(1024'("1x3f7==x=")), .LEN(9), .NCHAN(1), .WIDTH(4), .REPEAT(0))
    dut_a (.clock(clock), .resetn(resetn), .bus(ifa.slave));
  rvfi_seq_gen #(.SEQ(1024'("a5_-")), .LEN(4), .NCHAN(2), .WIDTH(2), .REPEAT(1))
    dut_b (.clock(clock), .resetn(resetn), .bus(ifb.slave));
  rvfi_seq_gen #(.SEQ(1024'("=5")), .LEN(2), .NCHAN(1), .WIDTH(4), .REPEAT(1))
    dut_c (.clock(clock), .resetn(resetn), .bus(ifc.slave));
  rvfi_seq_gen #(.SEQ(1024'("-B")), .LEN(2), .NCHAN(2), .WIDTH(3), .REPEAT(0))
    dut_d (.clock(clock), .resetn(resetn), .bus(ifd.slave));

  // DUT observations gathered into arrays indexed by instance
  logic [31:0] g_dout [4];
  logic [7:0]  g_en   [4];
  logic        g_busy [4];
  logic        g_done [4];
  logic [6:0]  g_step [4];
  assign g_dout[0] = 32'(ifa.dout); assign g_en[0] = 8'(ifa.en);
  assign g_dout[1] = 32'(ifb.dout); assign g_en[1] = 8'(ifb.en);
  assign g_dout[2] = 32'(ifc.dout); assign g_en[2] = 8'(ifc.en);
  assign g_dout[3] = 32'(ifd.dout); assign g_en[3] = 8'(ifd.en);
  assign g_busy[0] = ifa.busy; assign g_done[0] = ifa.done; assign g_step[0] = ifa.step_idx;
  assign g_busy[1] = ifb.busy; assign g_done[1] = ifb.done; assign g_step[1] = ifb.step_idx;
  assign g_busy[2] = ifc.busy; assign g_done[2] = ifc.done; assign g_step[2] = ifc.step_idx;
  assign g_busy[3] = ifd.busy; assign g_done[3] = ifd.done; assign g_step[3] = ifd.step_idx;

  // Model configuration and state: 0 = idle, 1 = playing, 2 = done pulse
  string       m_seq [4];
  int          m_nch [4];
  int          m_w   [4];
  int          m_rep [4];
  int          m_mode[4];
  int          m_pos [4];
  int          m_hold[4][8];
  logic [31:0] e_dout[4];
  logic [7:0]  e_en  [4];
  logic        e_busy[4];
  logic        e_done[4];
  logic [6:0]  e_step[4];

  function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0d expected=%0d at t=%0t", name, got, exp, $time);
    end
  endfunction

  function automatic void decode(byte ch, int hold, int w, output bit e, output int v);
    int mask;
    mask = (1 << w) - 1;
    e = 1'b1;
    if (ch inside {["0":"9"]})      v = (ch - "0") & mask;
    else if (ch inside {["a":"f"]}) v = (ch - "a" + 10) & mask;
    else if (ch inside {["A":"F"]}) v = (ch - "A" + 10) & mask;
    else if (ch == "_")             v = 0;
    else if (ch == "-")             v = mask;
    else if (ch == "=")             v = hold;
    else begin e = 1'b0; v = 0; end
  endfunction

  task automatic model_reset(int d);
    m_mode[d] = 0; m_pos[d] = 0;
    for (int k = 0; k < 8; k++) m_hold[d][k] = 0;
    e_dout[d] = 32'd0; e_en[d] = 8'd0; e_busy[d] = 1'b0; e_done[d] = 1'b0; e_step[d] = 7'd0;
  endtask

  task automatic model_clock(int d, bit st, bit stl);
    int  steps, nch, w, v;
    bit  e;
    nch   = m_nch[d];
    w     = m_w[d];
    steps = m_seq[d].len() / nch;
    if (m_mode[d] != 1) begin
      m_pos[d] = 0;
      if (st) begin
        m_mode[d] = 1;
        for (int k = 0; k < 8; k++) m_hold[d][k] = 0;
      end else begin
        m_mode[d] = 0;
      end
    end else if (st) begin
      m_pos[d] = 0;
      for (int k = 0; k < 8; k++) m_hold[d][k] = 0;
    end else if (!stl) begin
      for (int k = 0; k < nch; k++)
        if (e_en[d][k]) m_hold[d][k] = int'((e_dout[d] >> (k * w)) & ((32'd1 << w) - 32'd1));
      if (m_pos[d] == steps - 1) begin
        if (m_rep[d] != 0) m_pos[d] = 0;
        else m_mode[d] = 2;
      end else begin
        m_pos[d]++;
      end
    end
    e_dout[d] = 32'd0;
    e_en[d]   = 8'd0;
    e_busy[d] = (m_mode[d] == 1);
    e_done[d] = (m_mode[d] == 2);
    e_step[d] = 7'(m_pos[d]);
    if (m_mode[d] == 1) begin
      for (int k = 0; k < nch; k++) begin
        decode(m_seq[d][m_pos[d] * nch + nch - 1 - k], m_hold[d][k], w, e, v);
        e_en[d][k] = e;
        e_dout[d]  = e_dout[d] | (32'(v) << (k * w));
      end
    end
  endtask

  // Reference model advances on the same edges as the DUTs
  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int d = 0; d < 4; d++) model_reset(d);
    end else begin
      for (int d = 0; d < 4; d++) model_clock(d, start_v, stall_v);
    end
  end

  // Compare every instance against the model away from the active edge
  always @(negedge clock) begin
    for (int d = 0; d < 4; d++) begin
      check($sformatf("dut%0d_dout", d), g_dout[d], e_dout[d]);
      check($sformatf("dut%0d_en", d), 32'(g_en[d]), 32'(e_en[d]));
      check($sformatf("dut%0d_busy", d), 32'(g_busy[d]), 32'(e_busy[d]));
      check($sformatf("dut%0d_done", d), 32'(g_done[d]), 32'(e_done[d]));
      check($sformatf("dut%0d_step", d), 32'(g_step[d]), 32'(e_step[d]));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  int exp_a_dout [9] = '{1, 0, 3, 15, 7, 7, 7, 0, 7};
  int exp_a_en   [9] = '{1, 0, 1, 1, 1, 1, 1, 0, 1};

  initial begin
    m_seq[0] = "1x3f7==x="; m_nch[0] = 1; m_w[0] = 4; m_rep[0] = 0;
    m_seq[1] = "a5_-";      m_nch[1] = 2; m_w[1] = 2; m_rep[1] = 1;
    m_seq[2] = "=5";        m_nch[2] = 1; m_w[2] = 4; m_rep[2] = 1;
    m_seq[3] = "-B";        m_nch[3] = 2; m_w[3] = 3; m_rep[3] = 0;
    for (int d = 0; d < 4; d++) model_reset(d);

    // Reset state
    repeat (2) tick();
    @(negedge clock);
    check("rst_a_dout", g_dout[0], 32'd0);
    check("rst_a_busy", 32'(g_busy[0]), 32'd0);
    check("rst_b_step", 32'(g_step[1]), 32'd0);
    tick(); resetn = 1'b1;

    // First pass from a single start pulse
    tick(); start_v = 1'b1;
    tick(); start_v = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) tick();
      @(negedge clock);
      check($sformatf("lit_a_dout_s%0d", i), g_dout[0], 32'(exp_a_dout[i]));
      check($sformatf("lit_a_en_s%0d", i), 32'(g_en[0]), 32'(exp_a_en[i]));
      check($sformatf("lit_a_step_s%0d", i), 32'(g_step[0]), 32'(i));
      case (i)
        0: begin
          check("lit_b_step0", g_dout[1], 32'd9);
          check("lit_b_en0", 32'(g_en[1]), 32'd3);
          check("lit_c_hold_empty", g_dout[2], 32'd0);
          check("lit_d_single", g_dout[3], 32'd59);
        end
        1: begin
          check("lit_b_step1", g_dout[1], 32'd3);
          check("lit_c_step1", g_dout[2], 32'd5);
          check("lit_d_done", 32'(g_done[3]), 32'd1);
        end
        2: begin
          check("lit_b_wrap", g_dout[1], 32'd9);
          check("lit_b_wrap_step", 32'(g_step[1]), 32'd0);
          check("lit_c_hold_kept", g_dout[2], 32'd5);
          check("lit_d_idle", 32'(g_busy[3]), 32'd0);
        end
        default: check("lit_b_nodone", 32'(g_done[1]), 32'd0);
      endcase
    end
    tick(); @(negedge clock);
    check("lit_a_done", 32'(g_done[0]), 32'd1);
    check("lit_a_done_step", 32'(g_step[0]), 32'd8);
    check("lit_a_done_busy", 32'(g_busy[0]), 32'd0);
    tick(); @(negedge clock);
    check("lit_a_idle_done", 32'(g_done[0]), 32'd0);
    check("lit_a_idle_busy", 32'(g_busy[0]), 32'd0);

    // Stall for three cycles on step 2
    start_v = 1'b1;
    tick(); start_v = 1'b0;
    tick(); tick();
    stall_v = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); @(negedge clock);
      check("lit_stall_dout", g_dout[0], 32'd3);
      check("lit_stall_step", 32'(g_step[0]), 32'd2);
    end
    stall_v = 1'b0;
    tick(); @(negedge clock);
    check("lit_after_stall", g_dout[0], 32'd15);

    // Restart mid-run: hold values are cleared
    start_v = 1'b1;
    tick(); start_v = 1'b0;
    @(negedge clock);
    check("lit_restart_a", g_dout[0], 32'd1);
    check("lit_restart_c_hold", g_dout[2], 32'd0);
    check("lit_restart_c_en", 32'(g_en[2]), 32'd1);

    // Reset mid-run at step 2
    tick(); tick();
    #1 resetn = 1'b0;
    @(negedge clock);
    check("lit_midrst_dout", g_dout[0], 32'd0);
    check("lit_midrst_busy", 32'(g_busy[0]), 32'd0);
    tick(); resetn = 1'b1;
    tick(); tick(); @(negedge clock);
    check("lit_postrst_done", 32'(g_done[0]), 32'd0);
    check("lit_postrst_busy", 32'(g_busy[2]), 32'd0);

    // Randomized control traffic
    for (int n = 0; n < 4000; n++) begin
      tick();
      start_v = ($urandom_range(15) == 0);
      stall_v = ($urandom_range(3) == 0);
      if ($urandom_range(499) == 0) begin
        resetn = 1'b0;
        #2 resetn = 1'b1;
      end
    end
    tick();
    @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
